v810_bus_target: RTL and testbench
==================================

Name: v810_bus_target

Overview:
- Memory-side responder for the V810 external bus, i.e. the target end of the bus that v810_mem masters.
- Decodes an address window, inserts programmable wait states, and drives READYn and SZRQn.
- Returns read data onto a wired-OR data bus, and translates bus cycles into a synchronous SRAM port (1-cycle read latency, same timing as the team's ram model).
- Multiple instances share D_I (wor), READYn (wor) and SZRQn (wand).

Parameters:
- BASE, 32'h0000_0000: window base address.
- MASK, 32'hFFF0_0000: address bits compared against BASE.
- AW, 18: memory word-address width; MEM_A = A[AW+1:2].
- BUS16, 0: 1 = request 16-bit dynamic sizing (assert SZRQn on hits).

Ports:
- CLK  in  1  clock
- RES  in  1  asynchronous reset, active-high
- CE  in  1  clock enable; all state advances only when CE=1
- WS  in  4  wait states per access, sampled at cycle start
- A  in  32  bus address
- D_O  in  32  write data from controller
- D_I  out  32  read data to controller; 0 when not responding
- BEn  in  4  byte enables, active-low
- RW  in  1  1=read, 0=write
- MRQn  in  1  memory request, active-low
- BCYSTn  in  1  bus cycle start, active-low, one cycle
- DAn  in  1  data phase strobe, active-low
- READYn  out  1  ready, active-low; 0 when not stalling
- SZRQn  out  1  size request, active-low; 1 when not selected
- MEM_nCE  out  1  memory chip enable
- MEM_nWE  out  1  memory write enable
- MEM_nBE  out  4  memory byte enables
- MEM_A  out  AW  memory word address
- MEM_DI  out  32  memory write data (=D_O)
- MEM_DO  in  32  memory read data

Behaviour:
- Hit: hit = ~MRQn & ~BCYSTn & ((A & MASK) == (BASE & MASK)).
- States: IDLE, ACCESS.
- Reset (async, any time, including mid-cycle): state=IDLE, cnt=0, latched regs=0.
  - Outputs at reset: READYn=0, SZRQn=1, D_I=0, MEM_nCE=1, MEM_nWE=1, MEM_nBE=4'hF.
  - An aborted cycle is not resumed.
- IDLE, on a CE edge with hit:
  - Latch A[AW+1:2], BEn, RW.
  - cnt <= WS.
  - Go to ACCESS.
- Address-phase bypass: during IDLE with hit true, MEM_nCE=0, MEM_A=A[AW+1:2] and MEM_nBE=BEn are driven combinationally. The memory therefore samples the address on edge T0, and read data is valid in T0..T1.
- ACCESS:
  - MEM_nCE=0; MEM_A and MEM_nBE come from the latches.
  - READYn = (cnt != 0).
  - On a CE edge with cnt != 0: cnt <= cnt-1.
  - On a CE edge with cnt == 0 and DAn=0: the cycle completes and the state goes to IDLE.
  - With cnt == 0 and DAn=1: READYn=0 and the block holds in ACCESS until DAn=0.
- Latency: total bus cycle is 2+WS clocks (T0 address, then WS waits, then the ready clock).
- Read: D_I = MEM_DO only in ACCESS & RW=1 & cnt==0; otherwise D_I=0. MEM_nWE=1 throughout.
- Write:
  - MEM_nWE=0 only in ACCESS & RW=0 & cnt==0 & DAn=0, so the memory writes on the completing edge.
  - MEM_DI=D_O at all times.
- SZRQn: 0 when BUS16=1 and the block is either in ACCESS or in IDLE with hit; otherwise 1.
- Non-hits: READYn=0, D_I=0, SZRQn=1, so other targets are never blocked.
- BCYSTn low while in ACCESS: ignored (protocol violation); the current cycle continues.
- CE=0: all registers hold. Combinational outputs continue to reflect the held state.
- WS=0: no stall; READYn stays 0 throughout.
- WS=15: 15 stall clocks.
- cnt is 4 bits, decrements only while nonzero, and never wraps.

Test Plan:
- Read, WS=0, BASE=0, mem word 5 = 32'hDEADBEEF: BCYSTn/MRQn low with A=32'h14, RW=1 → READYn stays 0; D_I=32'hDEADBEEF in clock T1; D_I=0 at T2; MEM_nCE low for exactly 2 clocks.
- Write, WS=2, A=32'h8, BEn=4'b1100, D_O=32'h12345678: READYn=1 for 2 clocks then 0 → MEM_nWE low for exactly one clock, at the completing edge, with MEM_nBE=4'b1100; read-back of word 2 low half gives 16'h5678.
- Miss, BASE=32'hFFF00000: cycle at A=32'h100 → READYn=0, D_I=0, SZRQn=1, MEM_nCE=1 throughout.
- BUS16=1 hit → SZRQn=0 from T0 through the completing clock, then 1. CE toggling 1/0 with WS=1 → READYn high for exactly one CE-qualified clock.
- RES pulsed mid-wait (WS=8, after 3 clocks) → READYn=0, MEM_nCE=1 immediately without a clock edge. A new read after release completes normally in 2+WS clocks.
- DAn held high 3 clocks after cnt reaches 0 → state stays ACCESS, READYn=0, MEM_nWE=1. The write commits only on the edge where DAn=0.

Source files
------------

// File: rtl/v810_bus_target.sv
// v810_bus_target: memory-side responder on the V810 external bus.
//   Decodes a BASE/MASK window, stretches each hit cycle by WS wait states
//   (READYn high while stalling), drives SZRQn for 16-bit sizing, and maps
//   the bus cycle onto a synchronous SRAM port with a 1-cycle read latency.
// Latency: 2+WS clocks per hit (T0 address, WS waits, one ready clock),
//   extended for as long as DAn stays high once the waits have expired.
// Ports: CLK/RES/CE control; WS wait count; A/D_O/BEn/RW/MRQn/BCYSTn/DAn
//   bus inputs; D_I/READYn/SZRQn shared bus outputs (idle values 0/0/1);
//   MEM_* synchronous SRAM port.
module v810_bus_target #(
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter logic [31:0] MASK  = 32'hFFF0_0000,
  parameter int          AW    = 18,
  parameter bit          BUS16 = 1'b0
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          CE,
  input  logic [3:0]    WS,
  input  logic [31:0]   A,
  input  logic [31:0]   D_O,
  output logic [31:0]   D_I,
  input  logic [3:0]    BEn,
  input  logic          RW,
  input  logic          MRQn,
  input  logic          BCYSTn,
  input  logic          DAn,
  output logic          READYn,
  output logic          SZRQn,
  output logic          MEM_nCE,
  output logic          MEM_nWE,
  output logic [3:0]    MEM_nBE,
  output logic [AW-1:0] MEM_A,
  output logic [31:0]   MEM_DI,
  input  logic [31:0]   MEM_DO
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    ben_q, ben_d;
  logic          rw_q, rw_d;

  logic hit;
  logic hit_out;

  assign hit = ~MRQn & ~BCYSTn & ((A & MASK) == (BASE & MASK));

  // The address-phase bypass is combinational from the bus, so it must be
  // masked while reset is held to keep the memory port quiet.
  assign hit_out = hit & ~RES;

  // Write data is a straight pass-through; MEM_nWE alone qualifies it.
  assign MEM_DI = D_O;

  // State register
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      ben_q   <= 4'd0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ben_q   <= ben_d;
      rw_q    <= rw_d;
    end
  end

  // Next-state logic; nothing moves on a clock with CE low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ben_d   = ben_q;
    rw_d    = rw_q;
    if (CE) begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            state_d = S_ACCESS;
            cnt_d   = WS;
            addr_d  = A[AW+1:2];
            ben_d   = BEn;
            rw_d    = RW;
          end
        end
        S_ACCESS: begin
          // A BCYSTn seen here is a protocol violation and is ignored.
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (!DAn) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic. Idle values never block the shared READYn/SZRQn/D_I wires.
  always_comb begin
    READYn  = 1'b0;
    SZRQn   = 1'b1;
    D_I     = 32'd0;
    MEM_nCE = 1'b1;
    MEM_nWE = 1'b1;
    MEM_nBE = 4'hF;
    MEM_A   = addr_q;
    case (state_q)
      S_IDLE: begin
        if (hit_out) begin
          // T0: present the address now so read data is ready by T1.
          MEM_nCE = 1'b0;
          MEM_A   = A[AW+1:2];
          MEM_nBE = BEn;
          SZRQn   = ~BUS16;
        end
      end
      S_ACCESS: begin
        MEM_nCE = 1'b0;
        MEM_nBE = ben_q;
        SZRQn   = ~BUS16;
        READYn  = (cnt_q != 4'd0);
        if (cnt_q == 4'd0) begin
          if (rw_q) begin
            D_I = MEM_DO;
          end else begin
            // Strobe only on the completing clock so the SRAM writes once.
            MEM_nWE = DAn;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_v810_bus_target.sv
// tb_v810_bus_target: directed bench for v810_bus_target.
//   u0: BASE=0, 16-bit sizing off, backed by a small synchronous SRAM.
//   u1: BASE=FFF0_0000, 16-bit sizing on, MEM_DO tied to a constant.
module tb_v810_bus_target;

  localparam logic [31:0] C1 = 32'h5A5A_1234;

  logic        CLK = 1'b0;
  logic        RES, CE, MRQn, BCYSTn, DAn, RW;
  logic [3:0]  WS, BEn;
  logic [31:0] A, D_O;

  logic [31:0] d_i0, d_i1, mdi0, mdi1;
  logic        rdy0, rdy1, sz0, sz1, nce0, nce1, nwe0, nwe1;
  logic [3:0]  nbe0, nbe1;
  logic [17:0] ma0, ma1;
  logic [31:0] sram_q;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  v810_bus_target #(.BASE(32'h0000_0000), .MASK(32'hFFF0_0000), .AW(18), .BUS16(1'b0)) u0 (
    .CLK(CLK), .RES(RES), .CE(CE), .WS(WS), .A(A), .D_O(D_O), .D_I(d_i0), .BEn(BEn),
    .RW(RW), .MRQn(MRQn), .BCYSTn(BCYSTn), .DAn(DAn), .READYn(rdy0), .SZRQn(sz0),
    .MEM_nCE(nce0), .MEM_nWE(nwe0), .MEM_nBE(nbe0), .MEM_A(ma0), .MEM_DI(mdi0),
    .MEM_DO(sram_q)
  );

  v810_bus_target #(.BASE(32'hFFF0_0000), .MASK(32'hFFF0_0000), .AW(18), .BUS16(1'b1)) u1 (
    .CLK(CLK), .RES(RES), .CE(CE), .WS(WS), .A(A), .D_O(D_O), .D_I(d_i1), .BEn(BEn),
    .RW(RW), .MRQn(MRQn), .BCYSTn(BCYSTn), .DAn(DAn), .READYn(rdy1), .SZRQn(sz1),
    .MEM_nCE(nce1), .MEM_nWE(nwe1), .MEM_nBE(nbe1), .MEM_A(ma1), .MEM_DI(mdi1),
    .MEM_DO(C1)
  );

  // Physical SRAM behind u0: synchronous, 1-cycle read latency.
  logic [31:0] sram [0:255];
  always @(posedge CLK) begin
    if (!nce0) begin
      if (!nwe0) begin
        for (int b = 0; b < 4; b++)
          if (!nbe0[b]) sram[ma0[7:0]][8*b +: 8] = mdi0[8*b +: 8];
      end else begin
        sram_q <= sram[ma0[7:0]];
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  // Per target: busy flag, CE-clocks elapsed since T0, wait count, and the
  // cycle's attributes. The target stalls while elapsed <= WS, then is in
  // its ready phase until a CE clock with DAn low ends the cycle.
  logic [31:0] mref [0:255];
  logic        m_busy [0:1];
  int          m_el   [0:1];
  int          m_ws   [0:1];
  logic        m_rw   [0:1];
  logic [17:0] m_word [0:1];
  logic [3:0]  m_ben  [0:1];

  function automatic logic hit_m(input int i);
    logic in_win;
    in_win = (i == 0) ? (A < 32'h0010_0000) : (A >= 32'hFFF0_0000);
    return !MRQn && !BCYSTn && in_win;
  endfunction

  always @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_el[i]   = 0;
      end
    end else if (CE) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (hit_m(i)) begin
            m_busy[i] = 1'b1;
            m_el[i]   = 1;
            m_ws[i]   = int'(WS);
            m_rw[i]   = RW;
            m_word[i] = A[19:2];
            m_ben[i]  = BEn;
          end
        end else if (m_el[i] > m_ws[i]) begin
          if (!DAn) begin
            m_busy[i] = 1'b0;
            if (i == 0 && !m_rw[0])
              for (int b = 0; b < 4; b++)
                if (!m_ben[0][b]) mref[m_word[0][7:0]][8*b +: 8] = D_O[8*b +: 8];
          end
        end else begin
          m_el[i] = m_el[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic rdy, input logic sz, input logic nce,
                          input logic nwe, input logic [3:0] nbe, input logic [17:0] ma,
                          input logic [31:0] di, input logic [31:0] mdi);
    logic        t0, rph, e_nce, e_rdy, e_nwe, e_sz;
    logic [3:0]  e_nbe;
    logic [17:0] e_a;
    logic [31:0] e_di;
    t0    = !m_busy[i] && hit_m(i) && !RES;
    rph   = m_busy[i] && (m_el[i] > m_ws[i]);
    e_nce = !(m_busy[i] || t0);
    e_rdy = m_busy[i] && (m_el[i] <= m_ws[i]);
    e_di  = (rph && m_rw[i]) ? ((i == 0) ? mref[m_word[0][7:0]] : C1) : 32'd0;
    e_nwe = !(rph && !m_rw[i] && !DAn);
    e_nbe = m_busy[i] ? m_ben[i] : (t0 ? BEn : 4'hF);
    e_sz  = !((i == 1) && (m_busy[i] || t0));
    e_a   = m_busy[i] ? m_word[i] : A[19:2];
    chk($sformatf("u%0d READYn", i), 32'(rdy), 32'(e_rdy));
    chk($sformatf("u%0d SZRQn", i), 32'(sz), 32'(e_sz));
    chk($sformatf("u%0d MEM_nCE", i), 32'(nce), 32'(e_nce));
    chk($sformatf("u%0d MEM_nWE", i), 32'(nwe), 32'(e_nwe));
    chk($sformatf("u%0d MEM_nBE", i), 32'(nbe), 32'(e_nbe));
    chk($sformatf("u%0d D_I", i), di, e_di);
    chk($sformatf("u%0d MEM_DI", i), mdi, D_O);
    if (!e_nce) chk($sformatf("u%0d MEM_A", i), 32'(ma), 32'(e_a));
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp_inst(0, rdy0, sz0, nce0, nwe0, nbe0, ma0, d_i0, mdi0);
      cmp_inst(1, rdy1, sz1, nce1, nwe1, nbe1, ma1, d_i1, mdi1);
    end
  end

  // ---------------- per-test activity counters ----------------
  int c_nce0, c_nwe0, c_rdy0, c_nce1, c_rdy1, c_sz1, c_di1;
  logic [3:0] nbe_at_we;

  always @(negedge CLK) begin
    if (!nce0) c_nce0++;
    if (!nwe0) begin c_nwe0++; nbe_at_we = nbe0; end
    if (rdy0 && CE) c_rdy0++;
    if (!nce1) c_nce1++;
    if (rdy1) c_rdy1++;
    if (!sz1) c_sz1++;
    if (d_i1 != 32'd0) c_di1++;
  end

  task automatic clr();
    c_nce0 = 0; c_nwe0 = 0; c_rdy0 = 0; c_nce1 = 0; c_rdy1 = 0; c_sz1 = 0; c_di1 = 0;
    nbe_at_we = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One bus cycle from T0 until the model sees it complete. Called at
  // posedge+1. hold = ready-phase clocks with DAn kept high; ce_tog toggles
  // CE every clock after T0. nclk counts clocks from T0 through completion.
  task automatic run_cycle(input int inst, input logic [31:0] addr, input logic rw,
                           input logic [3:0] ws, input logic [3:0] ben, input logic [31:0] dout,
                           input int hold, input logic ce_tog,
                           output int nclk, output logic [31:0] rdat);
    int h;
    h = hold;
    A = addr; RW = rw; WS = ws; BEn = ben; D_O = dout;
    MRQn = 1'b0; BCYSTn = 1'b0; DAn = 1'b1; CE = 1'b1;
    nclk = 0; rdat = 32'd0;
    for (int k = 0; k < 64; k++) begin
      @(posedge CLK); #1;
      nclk++;
      BCYSTn = 1'b1; MRQn = 1'b1;
      if (ce_tog) CE = ~CE;
      if (!m_busy[inst]) break;
      if (m_el[inst] > m_ws[inst]) begin
        if (rw) rdat = (inst == 0) ? d_i0 : d_i1;
        if (h > 0) begin DAn = 1'b1; h--; end
        else DAn = 1'b0;
      end else begin
        DAn = 1'b0;
      end
    end
    chk("cycle completes within bound", 32'(m_busy[inst]), 32'd0);
    DAn = 1'b1; CE = 1'b1;
  endtask

  int nclk;
  logic [31:0] rdat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 32'h0101_0101 * i;
      mref[i] = 32'h0101_0101 * i;
    end
    sram[5] = 32'hDEAD_BEEF; mref[5] = 32'hDEAD_BEEF;
    sram[2] = 32'hAAAA_BBBB; mref[2] = 32'hAAAA_BBBB;
    sram_q = 32'd0;

    RES = 1'b1; CE = 1'b1; MRQn = 1'b1; BCYSTn = 1'b1; DAn = 1'b1; RW = 1'b1;
    WS = 4'd0; BEn = 4'hF; A = 32'd0; D_O = 32'd0;
    #1;
    chk("reset READYn", 32'(rdy0), 32'd0);
    chk("reset SZRQn u0", 32'(sz0), 32'd1);
    chk("reset SZRQn u1", 32'(sz1), 32'd1);
    chk("reset D_I", d_i0, 32'd0);
    chk("reset MEM_nCE", 32'(nce0), 32'd1);
    chk("reset MEM_nWE", 32'(nwe0), 32'd1);
    chk("reset MEM_nBE", 32'(nbe0), 32'hF);
    repeat (2) @(posedge CLK);
    #1 RES = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Read, WS=0, word 5
    clr();
    run_cycle(0, 32'h14, 1'b1, 4'd0, 4'h0, 32'd0, 0, 1'b0, nclk, rdat);
    chk("rd ws0 D_I at T1", rdat, 32'hDEAD_BEEF);
    chk("rd ws0 D_I at T2", d_i0, 32'd0);
    chk("rd ws0 clocks", 32'(nclk), 32'd2);
    idle(1);
    chk("rd ws0 MEM_nCE low clocks", 32'(c_nce0), 32'd2);
    chk("rd ws0 READYn high clocks", 32'(c_rdy0), 32'd0);

    // Write, WS=2, low half of word 2
    clr();
    run_cycle(0, 32'h8, 1'b0, 4'd2, 4'b1100, 32'h1234_5678, 0, 1'b0, nclk, rdat);
    idle(1);
    chk("wr ws2 READYn high clocks", 32'(c_rdy0), 32'd2);
    chk("wr ws2 MEM_nWE low clocks", 32'(c_nwe0), 32'd1);
    chk("wr ws2 MEM_nBE at write", 32'(nbe_at_we), 32'hC);
    chk("wr ws2 clocks", 32'(nclk), 32'd4);
    run_cycle(0, 32'h8, 1'b1, 4'd0, 4'h0, 32'd0, 0, 1'b0, nclk, rdat);
    chk("readback low half", 32'(rdat[15:0]), 32'h5678);
    chk("readback word", rdat, 32'hAAAA_5678);
    idle(1);

    // Miss on u1 while u0 takes the cycle with waits
    clr();
    run_cycle(0, 32'h100, 1'b1, 4'd3, 4'h0, 32'd0, 0, 1'b0, nclk, rdat);
    idle(1);
    chk("miss u1 MEM_nCE low clocks", 32'(c_nce1), 32'd0);
    chk("miss u1 READYn high clocks", 32'(c_rdy1), 32'd0);
    chk("miss u1 SZRQn low clocks", 32'(c_sz1), 32'd0);
    chk("miss u1 D_I nonzero clocks", 32'(c_di1), 32'd0);
    chk("miss u0 READYn high clocks", 32'(c_rdy0), 32'd3);

    // 16-bit sizing request on u1, WS=1
    clr();
    run_cycle(1, 32'hFFF0_0040, 1'b1, 4'd1, 4'h0, 32'd0, 0, 1'b0, nclk, rdat);
    chk("bus16 read data", rdat, C1);
    chk("bus16 clocks", 32'(nclk), 32'd3);
    idle(1);
    chk("bus16 SZRQn low clocks", 32'(c_sz1), 32'd3);
    chk("bus16 SZRQn after", 32'(sz1), 32'd1);

    // CE toggling, WS=1
    clr();
    run_cycle(0, 32'h20, 1'b1, 4'd1, 4'h0, 32'd0, 0, 1'b1, nclk, rdat);
    idle(1);
    chk("ce toggle READYn high CE clocks", 32'(c_rdy0), 32'd1);
    chk("ce toggle clocks", 32'(nclk), 32'd5);
    chk("ce toggle read data", rdat, 32'h0808_0808);

    // Reset pulsed mid-wait
    clr();
    A = 32'h40; RW = 1'b1; WS = 4'd8; BEn = 4'h0; MRQn = 1'b0; BCYSTn = 1'b0; DAn = 1'b1;
    idle(1);
    BCYSTn = 1'b1; MRQn = 1'b1; DAn = 1'b0;
    idle(3);
    chk("mid-wait READYn before reset", 32'(rdy0), 32'd1);
    #1 RES = 1'b1;
    #1;
    chk("async reset READYn", 32'(rdy0), 32'd0);
    chk("async reset MEM_nCE", 32'(nce0), 32'd1);
    idle(1);
    RES = 1'b0; DAn = 1'b1;
    idle(1);
    run_cycle(0, 32'h14, 1'b1, 4'd8, 4'h0, 32'd0, 0, 1'b0, nclk, rdat);
    chk("post-reset read clocks", 32'(nclk), 32'd10);
    chk("post-reset read data", rdat, 32'hDEAD_BEEF);
    idle(1);

    // Write with DAn held high three clocks after the waits expire
    clr();
    run_cycle(0, 32'h30, 1'b0, 4'd1, 4'h0, 32'hCAFE_BABE, 3, 1'b0, nclk, rdat);
    idle(1);
    chk("dan hold clocks", 32'(nclk), 32'd6);
    chk("dan hold MEM_nWE low clocks", 32'(c_nwe0), 32'd1);
    chk("dan hold READYn high clocks", 32'(c_rdy0), 32'd1);
    run_cycle(0, 32'h30, 1'b1, 4'd0, 4'h0, 32'd0, 0, 1'b0, nclk, rdat);
    chk("dan hold readback", rdat, 32'hCAFE_BABE);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
